hilo_muldiv: RTL and testbench

Iterative unsigned multiply/divide unit that owns the architectural HI and LO registers of the MIPS-lite core. It receives MULTU, DIVU, MTHI and MTLO requests from the execute stage, holds the core in stall through `busy` while a 32-step operation runs, and presents HI/LO to the execute stage for MFHI/MFLO. It sits beside the ALU and replaces any single-cycle HI/LO write path.

---
 rtl/hilo_muldiv_pkg.sv | 18 +
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/hilo_muldiv_divu_step.sv | 23 ++
 rtl/hilo_muldiv.sv | 139 +++++++++++++
 tb/tb_hilo_muldiv.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: request opcodes
// and the control state encoding used by the top and the testbench.
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    HILO_OP_MTHI  = 2'd0,
    HILO_OP_MTLO  = 2'd1,
    HILO_OP_MULTU = 2'd2,
    HILO_OP_DIVU  = 2'd3
  } hiloOp_e;

  typedef enum logic [1:0] {
    HILO_ST_IDLE = 2'd0,
    HILO_ST_MUL  = 2'd1,
    HILO_ST_DIV  = 2'd2
  } hiloState_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the execute stage (master) and the
// HI/LO multiply/divide unit (slave).
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  import hilo_muldiv_pkg::*;

  logic             start;
  hiloOp_e          op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, src_a, src_b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/hilo_muldiv_divu_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder and subtract the divisor when it fits.
module hilo_muldiv_divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  // The shifted remainder needs one extra bit, but when the subtraction
  // is taken the difference is below the divisor, so WIDTH bits suffice.
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;

  assign w_shifted = {i_rem, i_bit};
  assign w_diff    = w_shifted[WIDTH-1:0] - i_divisor;
  assign o_qbit    = (w_shifted >= {1'b0, i_divisor});
  assign o_rem     = o_qbit ? w_diff : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative unsigned multiply/divide unit owning the architectural HI/LO
// registers. MT ops complete in one cycle; MULTU/DIVU take WIDTH steps
// with busy held high and commit HI/LO only on the final step.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  hilo_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  hiloState_e         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_divZero;

  // Multiply datapath: accumulator plus a multiplicand that shifts left
  // while the multiplier shifts right, so bit 0 is always the next bit.
  logic [2*WIDTH-1:0] r_prodAcc;
  logic [2*WIDTH-1:0] r_mcandSh;
  logic [WIDTH-1:0]   r_mplier;

  // Divide datapath: the quotient register starts holding the dividend
  // and its MSB feeds the step while quotient bits enter at the bottom.
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;

  logic [2*WIDTH-1:0] w_prodNext;
  logic [WIDTH-1:0]   w_remNext;
  logic               w_qBit;
  logic [WIDTH-1:0]   w_quotNext;
  logic               w_lastStep;

  assign w_prodNext = r_prodAcc + (r_mplier[0] ? r_mcandSh : {2*WIDTH{1'b0}});
  assign w_quotNext = {r_quot[WIDTH-2:0], w_qBit};
  assign w_lastStep = (r_count == CW'(WIDTH - 1));

  hilo_muldiv_divu_step #(.WIDTH(WIDTH)) u_divStep (
    .i_rem     (r_rem),
    .i_divisor (r_divisor),
    .i_bit     (r_quot[WIDTH-1]),
    .o_rem     (w_remNext),
    .o_qbit    (w_qBit)
  );

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_divZero;

  // Control FSM, step counter and both datapaths; HI/LO change only on an
  // MT accept or on the final iterative step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HILO_ST_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      r_prodAcc <= '0;
      r_mcandSh <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        HILO_ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              HILO_OP_MTHI: r_hi <= bus.src_a;
              HILO_OP_MTLO: r_lo <= bus.src_a;
              HILO_OP_MULTU: begin
                r_prodAcc <= '0;
                r_mcandSh <= {{WIDTH{1'b0}}, bus.src_a};
                r_mplier  <= bus.src_b;
                r_count   <= '0;
                r_busy    <= 1'b1;
                r_state   <= HILO_ST_MUL;
              end
              HILO_OP_DIVU: begin
                r_rem     <= '0;
                r_quot    <= bus.src_a;
                r_divisor <= bus.src_b;
                r_divZero <= 1'b0;
                r_count   <= '0;
                r_busy    <= 1'b1;
                r_state   <= HILO_ST_DIV;
              end
              default: r_state <= HILO_ST_IDLE;
            endcase
          end
        end
        HILO_ST_MUL: begin
          r_prodAcc <= w_prodNext;
          r_mcandSh <= {r_mcandSh[2*WIDTH-2:0], 1'b0};
          r_mplier  <= {1'b0, r_mplier[WIDTH-1:1]};
          r_count   <= r_count + 1'b1;
          if (w_lastStep) begin
            r_hi    <= w_prodNext[2*WIDTH-1:WIDTH];
            r_lo    <= w_prodNext[WIDTH-1:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_state <= HILO_ST_IDLE;
          end
        end
        HILO_ST_DIV: begin
          r_rem   <= w_remNext;
          r_quot  <= w_quotNext;
          r_count <= r_count + 1'b1;
          if (w_lastStep) begin
            r_hi      <= w_remNext;
            r_lo      <= w_quotNext;
            r_divZero <= (r_divisor == '0);
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_state   <= HILO_ST_IDLE;
          end
        end
        default: r_state <= HILO_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed scenarios plus a random
// op stream, all compared against an arithmetic HI/LO model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;

  int nCompared;
  int nMismatched;

  logic [W-1:0] mHi, mLo;
  logic         mDz;
  logic [W-1:0] pHi, pLo;

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of HI/LO/div_zero in plain arithmetic.
  task automatic modelOp(input hiloOp_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    case (op)
      HILO_OP_MTHI: mHi = a;
      HILO_OP_MTLO: mLo = a;
      HILO_OP_MULTU: begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        mHi  = prod[2*W-1:W];
        mLo  = prod[W-1:0];
      end
      default: begin
        if (b == '0) begin
          mLo = '1;
          mHi = a;
          mDz = 1'b1;
        end else begin
          mLo = a / b;
          mHi = a % b;
          mDz = 1'b0;
        end
      end
    endcase
  endtask

  // Present one request for exactly one accept edge; returns just after it.
  task automatic applyStimulus(input hiloOp_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    pHi = mHi;
    pLo = mLo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    modelOp(op, a, b);
  endtask

  // Checks an MT op one cycle after its accept.
  task automatic checkMt(input string tag);
    @(negedge clk);
    checkOutput({tag, "_hi"}, bus.hi, mHi);
    checkOutput({tag, "_lo"}, bus.lo, mLo);
    checkOutput({tag, "_busy"}, bus.busy, 1'b0);
    checkOutput({tag, "_done"}, bus.done, 1'b0);
  endtask

  // Waits (bounded) for an iterative op to finish, checking the busy
  // window length, HI/LO stability mid-op and the committed result.
  // Optionally holds an MTHI request on the bus for the whole busy window.
  // Returns at the falling edge inside the done cycle.
  task automatic waitResult(input string tag, input bit holdMthi);
    int n;
    n = 0;
    if (holdMthi) begin
      bus.start = 1'b1;
      bus.op    = HILO_OP_MTHI;
      bus.src_a = 32'hDEADBEEF;
    end
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 100) begin
      if (n == W / 2) begin
        checkOutput({tag, "_midHi"}, bus.hi, pHi);
        checkOutput({tag, "_midLo"}, bus.lo, pLo);
      end
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput({tag, "_busyCycles"}, n, W);
    checkOutput({tag, "_done"}, bus.done, 1'b1);
    checkOutput({tag, "_hi"}, bus.hi, mHi);
    checkOutput({tag, "_lo"}, bus.lo, mLo);
    checkOutput({tag, "_divZero"}, bus.div_zero, mDz);
  endtask

  // Main sequence: directed scenarios followed by a random op stream.
  initial begin
    hiloOp_e rop;
    logic [W-1:0] ra, rb;
    nCompared   = 0;
    nMismatched = 0;
    mHi = '0;
    mLo = '0;
    mDz = 1'b0;
    pHi = '0;
    pLo = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = HILO_OP_MTHI;
    bus.src_a = '0;
    bus.src_b = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_hi", bus.hi, 0);
    checkOutput("reset_lo", bus.lo, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_divZero", bus.div_zero, 0);
    rst = 1'b0;

    @(negedge clk);
    applyStimulus(HILO_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitResult("mulMax", 1'b0);
    checkOutput("mulMax_hiConst", bus.hi, 32'hFFFFFFFE);
    checkOutput("mulMax_loConst", bus.lo, 32'h00000001);
    @(negedge clk);
    checkOutput("mulMax_donePulse", bus.done, 0);

    applyStimulus(HILO_OP_DIVU, 32'd100, 32'd7);
    waitResult("div100by7", 1'b0);
    @(negedge clk);

    applyStimulus(HILO_OP_DIVU, 32'd5, 32'd0);
    waitResult("div5by0", 1'b0);
    checkOutput("div5by0_dzConst", bus.div_zero, 1);
    @(negedge clk);
    applyStimulus(HILO_OP_DIVU, 32'd9, 32'd3);
    waitResult("div9by3", 1'b0);
    @(negedge clk);

    // Consecutive MTHI then MTLO accepts.
    applyStimulus(HILO_OP_MTHI, 32'h12345678, '0);
    bus.start = 1'b1;
    bus.op    = HILO_OP_MTLO;
    bus.src_a = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("mtPair_hi", bus.hi, 32'h12345678);
    checkOutput("mtPair_busy1", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    modelOp(HILO_OP_MTLO, 32'hCAFEF00D, '0);
    checkMt("mtPair");

    // MTHI held during a MULTU is ignored; DIVU issued in the done cycle.
    @(negedge clk);
    applyStimulus(HILO_OP_MULTU, 32'd3, 32'd4);
    waitResult("holdMul", 1'b1);
    applyStimulus(HILO_OP_DIVU, 32'd12, 32'd5);
    waitResult("b2bDiv", 1'b0);
    @(negedge clk);
    checkOutput("b2bDiv_donePulse", bus.done, 0);

    // Random stream; iterative ops chain back-to-back from the done cycle.
    for (int i = 0; i < 20; i++) begin
      rop = hiloOp_e'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
      if (rop == HILO_OP_DIVU && $urandom_range(0, 5) == 0) rb = '0;
      applyStimulus(rop, ra, rb);
      if (rop == HILO_OP_MTHI || rop == HILO_OP_MTLO)
        checkMt($sformatf("rand%0d_mt", i));
      else
        waitResult($sformatf("rand%0d_iter", i), 1'b0);
    end

    // Reset in the middle of a DIVU discards it entirely.
    @(negedge clk);
    applyStimulus(HILO_OP_MTHI, 32'h0000A5A5, '0);
    checkMt("preRst");
    applyStimulus(HILO_OP_DIVU, 32'd1000, 32'd3);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRst_busyBefore", bus.busy, 1);
    checkOutput("midRst_hiBefore", bus.hi, pHi);
    @(negedge clk);
    checkOutput("midRst_hi", bus.hi, 0);
    checkOutput("midRst_lo", bus.lo, 0);
    checkOutput("midRst_busy", bus.busy, 0);
    checkOutput("midRst_done", bus.done, 0);
    checkOutput("midRst_divZero", bus.div_zero, 0);
    rst = 1'b0;
    mHi = '0;
    mLo = '0;
    mDz = 1'b0;
    @(negedge clk);
    applyStimulus(HILO_OP_MULTU, 32'd2, 32'd3);
    waitResult("postRstMul", 1'b0);
    checkOutput("postRstMul_loConst", bus.lo, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
